exp_monitor: RTL

EXP_MONITOR -- requirements
Module: exp_monitor

---
 rtl/exp_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/exp_monitor.sv
// Connection expiration monitor: counts timebase ticks while a UDT link is established,
// requests keep-alives on each expiration and reports a broken link once the limit is reached.
`timescale 1ns/1ps

module exp_monitor #(
  parameter logic [7:0]  CONNECTED  = 8'b0000_0100,
  parameter int unsigned EXP_PERIOD = 16,
  parameter int unsigned EXP_LIMIT  = 16
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic [31:0] udt_state_i,
  input  logic        state_valid_i,
  output logic        state_ready_o,
  input  logic        tick_i,
  input  logic        pkt_rcvd_i,
  output logic        keepalive_valid_o,
  input  logic        keepalive_ready_i,
  output logic        brocken_o,
  output logic        brocken_valid_o,
  input  logic        brocken_ready_i,
  output logic [7:0]  exp_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    KA_REQ,
    BRK_REQ,
    DONE
  } fsm_t;

  localparam logic [15:0] LAST_TICK = 16'(EXP_PERIOD - 1);
  localparam logic [7:0]  LIMIT     = 8'(EXP_LIMIT);

  fsm_t        state;
  fsm_t        state_next;
  logic [7:0]  cur_state;
  logic [15:0] tick_cnt;
  logic [15:0] tick_next;
  logic [7:0]  exp_next;
  logic [7:0]  exp_inc;
  logic        connected;
  logic        expire;
  logic        unused_state_bits;

  // Only the low byte of the socket state carries the udt_state code.
  assign unused_state_bits = ^udt_state_i[31:8];

  assign connected = (cur_state == CONNECTED);
  assign expire    = tick_i && (tick_cnt == LAST_TICK);
  assign exp_inc   = (exp_cnt_o == 8'hFF) ? 8'hFF : exp_cnt_o + 8'd1;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      cur_state     <= '0;
      state_ready_o <= 1'b0;
    end else begin
      state_ready_o <= 1'b1;
      if (state_valid_i) begin
        cur_state <= udt_state_i[7:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    exp_next   = exp_cnt_o;
    if (state != IDLE && !connected) begin
      state_next = IDLE;
      tick_next  = '0;
      exp_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (connected) begin
            state_next = ARMED;
            tick_next  = '0;
            exp_next   = '0;
          end
        end
        ARMED, KA_REQ: begin
          // A received packet proves the peer is alive and outranks a same-cycle tick.
          if (pkt_rcvd_i) begin
            state_next = ARMED;
            tick_next  = '0;
            exp_next   = '0;
          end else begin
            if (state == KA_REQ && keepalive_ready_i) begin
              state_next = ARMED;
            end
            if (tick_i) begin
              tick_next = expire ? '0 : tick_cnt + 16'd1;
            end
            if (expire) begin
              exp_next = exp_inc;
              if (exp_inc == LIMIT) begin
                state_next = BRK_REQ;
              end else if (state == ARMED && exp_inc < LIMIT) begin
                state_next = KA_REQ;
              end
            end
          end
        end
        BRK_REQ: begin
          if (tick_i) begin
            tick_next = expire ? '0 : tick_cnt + 16'd1;
          end
          if (brocken_ready_i) begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Valid outputs are decoded from the next state so they are registered yet track the FSM.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state             <= IDLE;
      tick_cnt          <= '0;
      exp_cnt_o         <= '0;
      keepalive_valid_o <= 1'b0;
      brocken_valid_o   <= 1'b0;
      brocken_o         <= 1'b0;
    end else begin
      state             <= state_next;
      tick_cnt          <= tick_next;
      exp_cnt_o         <= exp_next;
      keepalive_valid_o <= (state_next == KA_REQ);
      brocken_valid_o   <= (state_next == BRK_REQ);
      brocken_o         <= (state_next == BRK_REQ);
    end
  end

endmodule
